// File: rtl/micro_udp_engine_arp_tx_mq.sv
// Queued ARP transmitter: buffers reply/request jobs in a small FIFO and
// serialises each 28-byte ARP payload onto an Avalon-ST stream of DATA_W bits.
//
// state  | meaning
// S_IDLE | no packet in flight; waits for a queued entry
// S_TX   | presenting beats of the packet register, beat_cnt selects the beat
module micro_udp_engine_arp_tx_mq #(
  parameter logic [47:0] CONFIG_MAC_ADDR = 48'h0,
  parameter logic [31:0] CONFIG_IP_ADDR  = 32'h0,
  parameter int          DATA_W          = 256,
  parameter int          FIFO_DEPTH      = 4,
  localparam int         EMPTY_W         = $clog2(DATA_W/8)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arp_reply,
  input  logic [47:0]        arp_reply_tha,
  input  logic [31:0]        arp_reply_tpa,
  input  logic               arp_request,
  input  logic [31:0]        arp_request_tpa,
  output logic [DATA_W-1:0]  arp_tx_data,
  output logic [EMPTY_W-1:0] arp_tx_empty,
  output logic               arp_tx_startofpacket,
  output logic               arp_tx_endofpacket,
  input  logic               arp_tx_ready,
  output logic               arp_tx_valid,
  output logic               fifo_full,
  output logic [15:0]        drop_cnt
);

  localparam int NB     = (224 + DATA_W - 1) / DATA_W;
  localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PAD_W  = NB*DATA_W - 224;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int ENT_W  = 81;

  typedef enum logic {S_IDLE, S_TX} state_t;

  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_pend;
  state_t             r_state, w_state_nxt;
  logic [BEAT_W-1:0]  r_beat_cnt, w_beat_nxt;
  logic [223:0]       r_pkt;
  logic [15:0]        r_drop_cnt;

  logic               w_pop, w_nempty, w_last;
  logic               w_wr_reply, w_wr_req;
  logic [CW-1:0]      w_space;
  logic [1:0]         w_ndrop;
  logic [16:0]        w_drop_sum;
  logic [ENT_W-1:0]   w_head;
  logic [NB*DATA_W-1:0] w_pkt_pad;

  assign w_nempty   = (r_count != '0);
  assign w_last     = (r_beat_cnt == BEAT_W'(NB-1));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pkt_pad  = {r_pkt, {PAD_W{1'b0}}};

  // A same-cycle pop frees a slot; the reply claims space before the request.
  always_comb begin
    w_space    = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
    w_wr_reply = arp_reply && (w_space != '0);
    w_wr_req   = arp_request && (w_space > CW'(w_wr_reply));
    w_ndrop    = 2'(arp_reply && !w_wr_reply) + 2'(arp_request && !w_wr_req);
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_ndrop);
  end

  always_ff @(posedge clk) begin
    if (w_wr_reply)
      r_mem[r_wr_ptr] <= {1'b1, arp_reply_tha, arp_reply_tpa};
    if (w_wr_req)
      r_mem[r_wr_ptr + AW'(w_wr_reply)] <= {1'b0, 48'h0, arp_request_tpa};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_wr_reply) + AW'(w_wr_req);
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_count    <= r_count + CW'(w_wr_reply) + CW'(w_wr_req) - CW'(w_pop);
      r_pend     <= w_nempty;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_pkt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_pop)
        r_pkt <= {16'h0001, 16'h0800, 8'h06, 8'h04,
                  (w_head[80] ? 16'd2 : 16'd1),
                  CONFIG_MAC_ADDR, CONFIG_IP_ADDR, w_head[79:0]};
    end
  end

  // Idle pops only once the queue has been non-empty for a full cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend && w_nempty) begin
          w_pop       = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = S_TX;
        end
      end
      S_TX: begin
        if (arp_tx_ready) begin
          if (!w_last) begin
            w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          end else if (w_nempty) begin
            w_pop      = 1'b1;
            w_beat_nxt = '0;
          end else begin
            w_beat_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    arp_tx_valid         = (r_state == S_TX);
    arp_tx_startofpacket = arp_tx_valid && (r_beat_cnt == '0);
    arp_tx_endofpacket   = arp_tx_valid && w_last;
    arp_tx_empty         = arp_tx_endofpacket ? EMPTY_W'(4) : '0;
    arp_tx_data          = arp_tx_valid
                           ? w_pkt_pad[NB*DATA_W-1 - DATA_W*int'(r_beat_cnt) -: DATA_W]
                           : '0;
    fifo_full            = (r_count == CW'(FIFO_DEPTH));
    drop_cnt             = r_drop_cnt;
  end

endmodule
